// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous RAM port between N_RD read channels and one write
//   channel. Requests are granted combinationally in round-robin order, the
//   granted access is registered onto the RAM port the following cycle, and
//   read responses are routed back to the issuing channel through a tag
//   pipeline that tracks the RAM read latency.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   rd_req/rd_addr       per-channel read request and word address
//   rd_gnt               one-hot read grant (combinational)
//   rd_valid/rd_data     per-channel response pulse and held response data
//   wr_req/wr_addr/
//   wr_data/wr_strb      write request, word address, data, byte enables
//   wr_gnt               write grant (combinational)
//   mem_en/mem_we/
//   mem_addr/mem_wdata/
//   mem_wstrb            registered RAM access port
//   mem_rdata            RAM read data, MEM_LAT cycles after a read mem_en
module mem_port_arbiter #(
  parameter int N_RD           = 3,
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LSB            = $clog2(AXI_WIDTH) - 3,
  parameter int AW             = AXI_ADDR_WIDTH - LSB,
  parameter int MEM_LAT        = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_RD-1:0]           rd_req,
  input  logic [N_RD*AW-1:0]        rd_addr,
  output logic [N_RD-1:0]           rd_gnt,
  output logic [N_RD-1:0]           rd_valid,
  output logic [N_RD*AXI_WIDTH-1:0] rd_data,
  input  logic                      wr_req,
  input  logic [AW-1:0]             wr_addr,
  input  logic [AXI_WIDTH-1:0]      wr_data,
  input  logic [AXI_WIDTH/8-1:0]    wr_strb,
  output logic                      wr_gnt,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [AXI_WIDTH-1:0]      mem_wdata,
  output logic [AXI_WIDTH/8-1:0]    mem_wstrb,
  input  logic [AXI_WIDTH-1:0]      mem_rdata
);

  // Requester N_RD is the write channel; reads are 0..N_RD-1.
  localparam int NR  = N_RD + 1;
  localparam int IDW = $clog2(NR);
  localparam int CW  = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int SW  = AXI_WIDTH / 8;

  logic [NR-1:0]          req_all;
  logic [NR-1:0]          gnt_vec;
  logic                   gnt_any;
  logic                   gnt_is_wr;
  logic [IDW-1:0]         gnt_idx;
  logic [IDW:0]           cand;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [AW-1:0]          rd_addr_sel;
  logic [CW-1:0]          rd_id;

  logic                   mem_en_q, mem_we_q;
  logic [AW-1:0]          mem_addr_q;
  logic [AXI_WIDTH-1:0]   mem_wdata_q;
  logic [SW-1:0]          mem_wstrb_q;
  logic [CW-1:0]          iss_id_q;

  logic [MEM_LAT-1:0]     tag_vld_q;
  logic [CW-1:0]          tag_id_q [MEM_LAT];
  logic [AXI_WIDTH-1:0]   rd_data_q [N_RD];

  // Round-robin search starting at ptr_q, the index after the last grant.
  // Grants are suppressed while reset is asserted so every output is 0.
  always_comb begin
    req_all = {wr_req, rd_req};
    gnt_vec = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        cand = {1'b0, ptr_q} + (IDW+1)'(i);
        if (cand >= (IDW+1)'(NR)) cand = cand - (IDW+1)'(NR);
        if (!gnt_any && req_all[cand[IDW-1:0]]) begin
          gnt_any                 = 1'b1;
          gnt_idx                 = cand[IDW-1:0];
          gnt_vec[cand[IDW-1:0]]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == IDW'(N_RD)) ? '0 : gnt_idx + 1'b1;
  end

  assign rd_gnt    = gnt_vec[N_RD-1:0];
  assign wr_gnt    = gnt_vec[N_RD];
  assign gnt_is_wr = gnt_vec[N_RD];

  // Address and channel id of the granted read (don't-care on write grants).
  always_comb begin
    rd_addr_sel = '0;
    rd_id       = '0;
    for (int k = 0; k < N_RD; k++) begin
      if (gnt_vec[k]) begin
        rd_addr_sel = rd_addr[k*AW +: AW];
        rd_id       = CW'(k);
      end
    end
  end

  // ---- issue stage: granted access registered onto the RAM port ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      iss_id_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mem_en_q <= gnt_any;
      if (gnt_any) begin
        mem_we_q <= gnt_is_wr;
        iss_id_q <= rd_id;
        if (gnt_is_wr) begin
          mem_addr_q  <= wr_addr;
          mem_wdata_q <= wr_data;
          mem_wstrb_q <= wr_strb;
        end else begin
          mem_addr_q  <= rd_addr_sel;
        end
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  // ---- tag pipeline: one stage per cycle of RAM read latency ----
  // Stage MEM_LAT-1 lines up with the cycle in which mem_rdata is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= mem_en_q & ~mem_we_q;
      tag_id_q[0]  <= iss_id_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // ---- response stage: route mem_rdata to the tagged channel ----
  // The returning word is forwarded in the rd_valid cycle and captured so the
  // channel keeps seeing it until its next response.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    for (int k = 0; k < N_RD; k++) begin
      rd_valid[k] = tag_vld_q[MEM_LAT-1] && (tag_id_q[MEM_LAT-1] == CW'(k));
      rd_data[k*AXI_WIDTH +: AXI_WIDTH] = rd_valid[k] ? mem_rdata : rd_data_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_RD; k++) rd_data_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_RD; k++) begin
        if (rd_valid[k]) rd_data_q[k] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int W  = 128;
  localparam int AW = 28;
  localparam int SW = 16;
  localparam int W3 = 3 * W;
  typedef logic [W3-1:0] w3_t;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instance a: MEM_LAT = 1
  logic          a_rst;
  logic [2:0]    a_rd_req, a_rd_gnt, a_rd_valid;
  logic [3*AW-1:0] a_rd_addr;
  logic [3*W-1:0]  a_rd_data;
  logic          a_wr_req, a_wr_gnt, a_mem_en, a_mem_we;
  logic [AW-1:0] a_wr_addr, a_mem_addr;
  logic [W-1:0]  a_wr_data, a_mem_wdata, a_mem_rdata;
  logic [SW-1:0] a_wr_strb, a_mem_wstrb;

  // instance b: MEM_LAT = 3
  logic          b_rst;
  logic [2:0]    b_rd_req, b_rd_gnt, b_rd_valid;
  logic [3*AW-1:0] b_rd_addr;
  logic [3*W-1:0]  b_rd_data;
  logic          b_wr_req, b_wr_gnt, b_mem_en, b_mem_we;
  logic [AW-1:0] b_wr_addr, b_mem_addr;
  logic [W-1:0]  b_wr_data, b_mem_wdata, b_mem_rdata;
  logic [SW-1:0] b_wr_strb, b_mem_wstrb;

  mem_port_arbiter #(.N_RD(3), .AXI_WIDTH(W), .AXI_ADDR_WIDTH(32), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst(a_rst), .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_gnt(a_rd_gnt),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .wr_req(a_wr_req), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_strb(a_wr_strb), .wr_gnt(a_wr_gnt), .mem_en(a_mem_en),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata));

  mem_port_arbiter #(.N_RD(3), .AXI_WIDTH(W), .AXI_ADDR_WIDTH(32), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(b_rst), .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_gnt(b_rd_gnt),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .wr_req(b_wr_req), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_strb(b_wr_strb), .wr_gnt(b_wr_gnt), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata));

  // RAM models: read-after-write ordered, byte-strobed writes, preload port.
  logic          ld_en;
  logic [7:0]    ld_addr;
  logic [W-1:0]  ld_data;
  logic [W-1:0]  a_ram [256];
  logic [W-1:0]  b_ram [256];
  logic [W-1:0]  a_rq;
  logic [W-1:0]  b_rq [3];

  always @(posedge clk) begin
    if (ld_en) a_ram[ld_addr] <= ld_data;
    else if (a_mem_en && a_mem_we)
      for (int i = 0; i < SW; i++)
        if (a_mem_wstrb[i]) a_ram[a_mem_addr[7:0]][i*8 +: 8] <= a_mem_wdata[i*8 +: 8];
    if (a_mem_en && !a_mem_we) a_rq <= a_ram[a_mem_addr[7:0]];
  end
  assign a_mem_rdata = a_rq;

  always @(posedge clk) begin
    if (ld_en) b_ram[ld_addr] <= ld_data;
    else if (b_mem_en && b_mem_we)
      for (int i = 0; i < SW; i++)
        if (b_mem_wstrb[i]) b_ram[b_mem_addr[7:0]][i*8 +: 8] <= b_mem_wdata[i*8 +: 8];
    if (b_mem_en && !b_mem_we) b_rq[0] <= b_ram[b_mem_addr[7:0]];
    b_rq[1] <= b_rq[0];
    b_rq[2] <= b_rq[1];
  end
  assign b_mem_rdata = b_rq[2];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input w3_t obs, input w3_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] addr, input logic [W-1:0] data);
    ld_addr = addr;
    ld_data = data;
    ld_en   = 1'b1;
    tick();
    ld_en   = 1'b0;
  endtask

  localparam logic [W-1:0] DA5  = {4{32'hA5A5A5A5}};
  localparam logic [W-1:0] D60  = {4{32'h60606060}};
  localparam logic [W-1:0] D61  = {4{32'h61616161}};
  localparam logic [W-1:0] D62  = {4{32'h62626262}};
  localparam logic [W-1:0] DOLD = {{15{8'hFF}}, 8'h00};
  localparam logic [W-1:0] DNEW = {{15{8'hFF}}, 8'h34};

  int          exp_i, prev_i, last0, max_gap, bad;
  int          gcnt [4];
  int          vcnt [3];
  logic [3:0]  pend, g;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_rd_req = '0; a_rd_addr = '0; a_wr_req = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_strb = '0;
    b_rd_req = '0; b_rd_addr = '0; b_wr_req = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_strb = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    load(8'h10, DA5);
    load(8'h60, D60);
    load(8'h61, D61);
    load(8'h62, D62);

    // Reset state, with requests present to show grants stay low.
    a_rd_req = 3'b111; a_wr_req = 1'b1;
    #1;
    chk("rst_rd_gnt", w3_t'(a_rd_gnt), w3_t'(3'b000));
    chk("rst_wr_gnt", w3_t'(a_wr_gnt), w3_t'(1'b0));
    chk("rst_mem_en", w3_t'(a_mem_en), w3_t'(1'b0));
    chk("rst_mem_addr", w3_t'(a_mem_addr), w3_t'(0));
    chk("rst_rd_valid", w3_t'(a_rd_valid), w3_t'(3'b000));
    chk("rst_rd_data", w3_t'(a_rd_data), w3_t'(0));
    a_rd_req = '0; a_wr_req = 1'b0;
    tick();
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("idle_mem_en", w3_t'(a_mem_en), w3_t'(1'b0));

    // Single read, MEM_LAT=1.
    tick();
    a_rd_req = 3'b010; a_rd_addr[AW +: AW] = 28'h10;
    #1;
    chk("t1_rd_gnt", w3_t'(a_rd_gnt), w3_t'(3'b010));
    chk("t1_wr_gnt", w3_t'(a_wr_gnt), w3_t'(1'b0));
    tick();
    a_rd_req = '0;
    #1;
    chk("t1_mem_en", w3_t'(a_mem_en), w3_t'(1'b1));
    chk("t1_mem_we", w3_t'(a_mem_we), w3_t'(1'b0));
    chk("t1_mem_addr", w3_t'(a_mem_addr), w3_t'(28'h10));
    chk("t1_early_valid", w3_t'(a_rd_valid), w3_t'(3'b000));
    tick();
    chk("t1_rd_valid", w3_t'(a_rd_valid), w3_t'(3'b010));
    chk("t1_rd_data", w3_t'(a_rd_data[W +: W]), w3_t'(DA5));
    chk("t1_mem_en_off", w3_t'(a_mem_en), w3_t'(1'b0));
    tick();
    chk("t1_valid_pulse", w3_t'(a_rd_valid), w3_t'(3'b000));
    chk("t1_data_held", w3_t'(a_rd_data[W +: W]), w3_t'(DA5));

    // Write then read the same address.
    tick();
    a_wr_req = 1'b1; a_wr_addr = 28'h20; a_wr_data = 128'h1234; a_wr_strb = '1;
    #1;
    chk("t2_wr_gnt", w3_t'(a_wr_gnt), w3_t'(1'b1));
    chk("t2_rd_gnt", w3_t'(a_rd_gnt), w3_t'(3'b000));
    tick();
    a_wr_req = 1'b0; a_rd_req = 3'b001; a_rd_addr[0 +: AW] = 28'h20;
    #1;
    chk("t2_rd0_gnt", w3_t'(a_rd_gnt), w3_t'(3'b001));
    chk("t2_mem_we", w3_t'(a_mem_we), w3_t'(1'b1));
    chk("t2_mem_addr", w3_t'(a_mem_addr), w3_t'(28'h20));
    chk("t2_mem_wdata", w3_t'(a_mem_wdata), w3_t'(128'h1234));
    chk("t2_mem_wstrb", w3_t'(a_mem_wstrb), w3_t'(16'hFFFF));
    tick();
    a_rd_req = '0;
    #1;
    chk("t2_mem_rd", w3_t'({a_mem_en, a_mem_we}), w3_t'(2'b10));
    tick();
    chk("t2_rd_valid", w3_t'(a_rd_valid), w3_t'(3'b001));
    chk("t2_rd_data", w3_t'(a_rd_data[0 +: W]), w3_t'(128'h1234));

    // Partial-strobe write over an older full word.
    tick();
    a_wr_req = 1'b1; a_wr_data = DOLD; a_wr_strb = '1;
    #1;
    chk("t3_wr_gnt_a", w3_t'(a_wr_gnt), w3_t'(1'b1));
    tick();
    a_wr_data = 128'h1234; a_wr_strb = 16'h0001;
    #1;
    chk("t3_wr_gnt_b", w3_t'(a_wr_gnt), w3_t'(1'b1));
    tick();
    a_wr_req = 1'b0; a_rd_req = 3'b001;
    #1;
    chk("t3_rd0_gnt", w3_t'(a_rd_gnt), w3_t'(3'b001));
    chk("t3_mem_wstrb", w3_t'(a_mem_wstrb), w3_t'(16'h0001));
    tick();
    a_rd_req = '0;
    tick();
    chk("t3_rd_valid", w3_t'(a_rd_valid), w3_t'(3'b001));
    chk("t3_rd_data", w3_t'(a_rd_data[0 +: W]), w3_t'(DNEW));

    // Zero-strobe write still issues an access but changes nothing.
    tick();
    a_wr_req = 1'b1; a_wr_data = '1; a_wr_strb = '0;
    #1;
    chk("t4_wr_gnt", w3_t'(a_wr_gnt), w3_t'(1'b1));
    tick();
    a_wr_req = 1'b0; a_rd_req = 3'b001;
    #1;
    chk("t4_mem_en_we", w3_t'({a_mem_en, a_mem_we}), w3_t'(2'b11));
    chk("t4_mem_wstrb", w3_t'(a_mem_wstrb), w3_t'(16'h0000));
    tick();
    a_rd_req = '0;
    tick();
    chk("t4_rd_valid", w3_t'(a_rd_valid), w3_t'(3'b001));
    chk("t4_rd_data", w3_t'(a_rd_data[0 +: W]), w3_t'(DNEW));

    // All four requesters held high from reset: order 0,1,2,W,0,...
    tick();
    a_rst = 1'b1;
    a_rd_addr = {28'h42, 28'h41, 28'h40};
    a_wr_addr = 28'h50; a_wr_data = 128'h55; a_wr_strb = '1;
    a_rd_req = 3'b111; a_wr_req = 1'b1;
    #1;
    chk("t5_rst_gnt", w3_t'({a_wr_gnt, a_rd_gnt}), w3_t'(4'b0000));
    chk("t5_rst_data", w3_t'(a_rd_data), w3_t'(0));
    tick();
    a_rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      exp_i = i % 4;
      chk($sformatf("t5_gnt_%0d", i), w3_t'({a_wr_gnt, a_rd_gnt}), w3_t'(4'b0001 << exp_i));
      if (i > 0) begin
        prev_i = (i - 1) % 4;
        chk($sformatf("t5_mem_en_%0d", i), w3_t'(a_mem_en), w3_t'(1'b1));
        chk($sformatf("t5_mem_addr_%0d", i), w3_t'(a_mem_addr),
            w3_t'((prev_i < 3) ? 28'h40 + 28'(prev_i) : 28'h50));
      end
    end
    tick();
    a_rd_req = '0; a_wr_req = 1'b0;

    // MEM_LAT=3: reads on channels 2,0,2 back to back.
    tick();
    b_rd_req = 3'b100; b_rd_addr[2*AW +: AW] = 28'h60;
    #1;
    chk("t6_gnt_c0", w3_t'(b_rd_gnt), w3_t'(3'b100));
    tick();
    b_rd_req = 3'b001; b_rd_addr[0 +: AW] = 28'h61;
    #1;
    chk("t6_gnt_c1", w3_t'(b_rd_gnt), w3_t'(3'b001));
    tick();
    b_rd_req = 3'b100; b_rd_addr[2*AW +: AW] = 28'h62;
    #1;
    chk("t6_gnt_c2", w3_t'(b_rd_gnt), w3_t'(3'b100));
    tick();
    b_rd_req = '0;
    #1;
    chk("t6_valid_c3", w3_t'(b_rd_valid), w3_t'(3'b000));
    tick();
    chk("t6_valid_c4", w3_t'(b_rd_valid), w3_t'(3'b100));
    chk("t6_data2_c4", w3_t'(b_rd_data[2*W +: W]), w3_t'(D60));
    chk("t6_data0_c4", w3_t'(b_rd_data[0 +: W]), w3_t'(0));
    tick();
    chk("t6_valid_c5", w3_t'(b_rd_valid), w3_t'(3'b001));
    chk("t6_data0_c5", w3_t'(b_rd_data[0 +: W]), w3_t'(D61));
    tick();
    chk("t6_valid_c6", w3_t'(b_rd_valid), w3_t'(3'b100));
    chk("t6_data2_c6", w3_t'(b_rd_data[2*W +: W]), w3_t'(D62));
    chk("t6_data0_c6", w3_t'(b_rd_data[0 +: W]), w3_t'(D61));
    tick();
    chk("t6_valid_c7", w3_t'(b_rd_valid), w3_t'(3'b000));

    // MEM_LAT=3: reset one cycle after a read is issued.
    tick();
    b_rd_req = 3'b010; b_rd_addr[AW +: AW] = 28'h60;
    #1;
    chk("t7_gnt", w3_t'(b_rd_gnt), w3_t'(3'b010));
    tick();
    b_rd_req = '0;
    #1;
    chk("t7_issue", w3_t'(b_mem_en), w3_t'(1'b1));
    tick();
    b_rst = 1'b1;
    #1;
    chk("t7_rst_mem", w3_t'({b_mem_en, b_mem_we, b_mem_addr}), w3_t'(0));
    chk("t7_rst_valid", w3_t'(b_rd_valid), w3_t'(3'b000));
    chk("t7_rst_data", w3_t'(b_rd_data), w3_t'(0));
    tick();
    tick();
    b_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t7_no_valid_%0d", i), w3_t'(b_rd_valid), w3_t'(3'b000));
    end
    b_rd_req = 3'b110; b_wr_req = 1'b1;
    #1;
    chk("t7_first_gnt", w3_t'({b_wr_gnt, b_rd_gnt}), w3_t'(4'b0010));
    tick();
    b_rd_req = '0; b_wr_req = 1'b0;

    // Randomised fairness run on MEM_LAT=1 with channel 0 always requesting.
    pend = '0; last0 = -1; max_gap = 0; bad = 0;
    for (int k = 0; k < 4; k++) gcnt[k] = 0;
    for (int k = 0; k < 3; k++) vcnt[k] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        if (!pend[k]) begin
          pend[k] = (k == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
          a_rd_addr[k*AW +: AW] = AW'($urandom_range(0, 255));
        end
      end
      if (!pend[3]) begin
        pend[3]   = ($urandom_range(0, 3) == 0);
        a_wr_addr = AW'($urandom_range(0, 255));
        a_wr_data = {$urandom, $urandom, $urandom, $urandom};
        a_wr_strb = SW'($urandom);
      end
      a_rd_req = pend[2:0];
      a_wr_req = pend[3];
      #1;
      g = {a_wr_gnt, a_rd_gnt};
      if (g == 4'b0000 || !$onehot(g) || (g & ~pend) != 4'b0000) bad++;
      for (int k = 0; k < 3; k++) if (a_rd_valid[k]) vcnt[k]++;
      if (g[0]) begin
        if (cyc - last0 > max_gap) max_gap = cyc - last0;
        last0 = cyc;
      end
      for (int k = 0; k < 4; k++) begin
        if (g[k]) begin
          pend[k] = 1'b0;
          gcnt[k]++;
        end
      end
    end
    tick();
    a_rd_req = '0; a_wr_req = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) if (a_rd_valid[k]) vcnt[k]++;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int k = 0; k < 3; k++) if (a_rd_valid[k]) vcnt[k]++;
    end
    chk("t8_bad_grant_cycles", w3_t'(bad), w3_t'(0));
    chk("t8_gap_le_4", w3_t'(max_gap <= 4), w3_t'(1'b1));
    for (int k = 0; k < 3; k++)
      chk($sformatf("t8_valid_eq_gnt_%0d", k), w3_t'(vcnt[k]), w3_t'(gcnt[k]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
